// File: rtl/tetris_input_ctrl.sv
// Turns debounced button levels/pulses into a serial stream of game actions with DAS auto-repeat.
// Latency: btn_down to act_valid is 2 cycles with nothing pending; one action per accepted handshake.
// Backpressure: act_code/act_valid hold while !act_ready; requests coalesce in per-type pending bits.
module tetris_input_ctrl #(
  parameter int CNT_W       = 24,
  parameter int DAS_DELAY   = 16000000,
  parameter int ARR_PERIOD  = 5000000,
  parameter int SOFT_PERIOD = 3000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] btn_state,
  input  logic [3:0] btn_down,
  input  logic       act_ready,
  output logic       act_valid,
  output logic [2:0] act_code
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} ch_state_t;

  localparam logic [CNT_W-1:0] DAS_LAST  = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] ARR_LAST  = CNT_W'(ARR_PERIOD - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_PERIOD - 1);

  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_LEFT   = 3'd1;
  localparam logic [2:0] CODE_RIGHT  = 3'd2;
  localparam logic [2:0] CODE_ROTATE = 3'd3;
  localparam logic [2:0] CODE_SOFT   = 3'd4;

  // Channel index: 0 left, 1 right, 2 soft-drop (button bit 3).
  ch_state_t        st_q  [3];
  ch_state_t        st_d  [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic [3:0] held;
  logic       conflict;
  logic       conflict_q;
  logic       conflict_d;
  logic [3:0] req;
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [3:0] load_mask;
  logic       slot_free;
  logic       valid_d;
  logic [2:0] code_d;
  logic [2:0] sel_code;
  logic       unused_rot_lvl;

  // Rotate fires on the press pulse alone; its level is never consulted.
  assign unused_rot_lvl = btn_state[2];

  assign held       = btn_state | btn_down;
  assign conflict   = held[0] & held[1];
  assign conflict_d = enable & conflict;

  always_comb begin
    req = '0;
    for (int c = 0; c < 3; c++) begin
      st_d[c]  = st_q[c];
      cnt_d[c] = cnt_q[c];
    end

    // conflict_q marks the cycle the opposite direction was let go: restart as a fresh press.
    for (int c = 0; c < 2; c++) begin
      if (!enable || !held[c] || conflict) begin
        st_d[c]  = IDLE;
        cnt_d[c] = '0;
      end else begin
        case (st_q[c])
          IDLE: begin
            if (btn_down[c] || conflict_q) begin
              req[c]   = 1'b1;
              st_d[c]  = DELAY;
              cnt_d[c] = '0;
            end
          end
          DELAY: begin
            if (cnt_q[c] == DAS_LAST) begin
              req[c]   = 1'b1;
              st_d[c]  = REPEAT;
              cnt_d[c] = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + 1'b1;
            end
          end
          REPEAT: begin
            if (cnt_q[c] == ARR_LAST) begin
              req[c]   = 1'b1;
              cnt_d[c] = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + 1'b1;
            end
          end
          default: begin
            st_d[c]  = IDLE;
            cnt_d[c] = '0;
          end
        endcase
      end
    end

    if (!enable || !held[3]) begin
      st_d[2]  = IDLE;
      cnt_d[2] = '0;
    end else begin
      case (st_q[2])
        IDLE: begin
          if (btn_down[3]) begin
            req[3]   = 1'b1;
            st_d[2]  = REPEAT;
            cnt_d[2] = '0;
          end
        end
        REPEAT: begin
          if (cnt_q[2] == SOFT_LAST) begin
            req[3]   = 1'b1;
            cnt_d[2] = '0;
          end else begin
            cnt_d[2] = cnt_q[2] + 1'b1;
          end
        end
        default: begin
          st_d[2]  = IDLE;
          cnt_d[2] = '0;
        end
      endcase
    end

    req[2] = enable & btn_down[2];
  end

  assign slot_free = !act_valid || act_ready;

  always_comb begin
    load_mask = '0;
    sel_code  = CODE_NONE;
    if (pend_q[2]) begin
      load_mask[2] = 1'b1;
      sel_code     = CODE_ROTATE;
    end else if (pend_q[0]) begin
      load_mask[0] = 1'b1;
      sel_code     = CODE_LEFT;
    end else if (pend_q[1]) begin
      load_mask[1] = 1'b1;
      sel_code     = CODE_RIGHT;
    end else if (pend_q[3]) begin
      load_mask[3] = 1'b1;
      sel_code     = CODE_SOFT;
    end
    if (!slot_free) begin
      load_mask = '0;
    end
  end

  // A request on a bit that is already set is dropped; loading clears the bit.
  always_comb begin
    pend_d  = '0;
    valid_d = 1'b0;
    code_d  = CODE_NONE;
    if (enable) begin
      pend_d = (pend_q | req) & ~load_mask;
      if (!slot_free) begin
        valid_d = act_valid;
        code_d  = act_code;
      end else if (|pend_q) begin
        valid_d = 1'b1;
        code_d  = sel_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        st_q[c]  <= IDLE;
        cnt_q[c] <= '0;
      end
      conflict_q <= 1'b0;
      pend_q     <= '0;
      act_valid  <= 1'b0;
      act_code   <= CODE_NONE;
    end else begin
      for (int c = 0; c < 3; c++) begin
        st_q[c]  <= st_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      conflict_q <= conflict_d;
      pend_q     <= pend_d;
      act_valid  <= valid_d;
      act_code   <= code_d;
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: per-cycle vector table for handshake corners, scoreboard for repeat timing.
module tb_tetris_input_ctrl;

  localparam int CW   = 8;
  localparam int DAS  = 10;
  localparam int ARR  = 4;
  localparam int SOFT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] btn_state;
  logic [3:0] btn_down;
  logic       act_ready;
  logic       act_valid;
  logic [2:0] act_code;

  always #5 clk = ~clk;

  tetris_input_ctrl #(
    .CNT_W      (CW),
    .DAS_DELAY  (DAS),
    .ARR_PERIOD (ARR),
    .SOFT_PERIOD(SOFT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .btn_state(btn_state),
    .btn_down (btn_down),
    .act_ready(act_ready),
    .act_valid(act_valid),
    .act_code (act_code)
  );

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } exp_t;

  typedef struct {
    logic [3:0] st;
    logic [3:0] dn;
    logic       rdy;
    logic       exp_vld;
    logic [2:0] exp_code;
  } vec_t;

  int   n_cmp   = 0;
  int   n_err   = 0;
  int   cyc_cnt = 0;
  int   base    = 0;
  bit   mon_en  = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, req, $time);
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] dn, input logic rdy, input logic en);
    btn_state = st;
    btn_down  = dn;
    act_ready = rdy;
    enable    = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_act(input int c, input logic [2:0] code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic end_scn(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic add_vec(input logic [3:0] st, input logic [3:0] dn, input logic rdy,
                         input logic vld, input logic [2:0] code);
    vec_t v;
    v.st = st; v.dn = dn; v.rdy = rdy; v.exp_vld = vld; v.exp_code = code;
    tbl.push_back(v);
  endtask

  // Every accepted action must match the head of the scoreboard, code and cycle alike.
  always @(negedge clk) begin
    if (mon_en && rst_n && act_valid === 1'b1 && act_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_action: got code %0d at cycle %0d, required none", act_code, cyc_cnt - base);
      end else begin
        mon_e = sb.pop_front();
        chk("action_code", act_code, mon_e.code);
        chk("action_cycle", cyc_cnt - base, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Backpressure vectors: rotate+left+down together, then rotate taps while blocked.
    add_vec(4'b0000, 4'b1101, 1'b0, 1'b0, 3'd0);
    add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0);
    add_vec(4'b0000, 4'b0000, 1'b0, 1'b1, 3'd3);
    add_vec(4'b0000, 4'b0000, 1'b0, 1'b1, 3'd3);
    add_vec(4'b0000, 4'b0000, 1'b1, 1'b1, 3'd3);
    add_vec(4'b0000, 4'b0000, 1'b1, 1'b1, 3'd1);
    add_vec(4'b0000, 4'b0000, 1'b1, 1'b1, 3'd4);
    add_vec(4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0);
    add_vec(4'b0000, 4'b0100, 1'b0, 1'b0, 3'd0);
    add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0);
    add_vec(4'b0000, 4'b0100, 1'b0, 1'b1, 3'd3);
    add_vec(4'b0000, 4'b0100, 1'b0, 1'b1, 3'd3);
    add_vec(4'b0000, 4'b0100, 1'b0, 1'b1, 3'd3);
    add_vec(4'b0000, 4'b0000, 1'b1, 1'b1, 3'd3);
    add_vec(4'b0000, 4'b0000, 1'b1, 1'b1, 3'd3);
    add_vec(4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0);
    add_vec(4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0);

    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    chk("reset_valid", act_valid, 0);
    chk("reset_code", act_code, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    tick();
    tick();
    mon_en = 1'b1;

    // Tap left: one LEFT two cycles after the pulse, short hold never reaches DAS.
    base = cyc_cnt;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) expect_act(2, 3'd1);
      drive((c >= 1 && c <= 5) ? 4'b0001 : 4'b0000, (c == 0) ? 4'b0001 : 4'b0000, 1'b1, 1'b1);
      tick();
    end
    end_scn("tap_left_missing");

    // Hold right through cycle 29: requests at 0, 10, then every 4.
    base = cyc_cnt;
    for (int c = 0; c < 36; c++) begin
      if (c == 0 || c == 10 || c == 14 || c == 18 || c == 22 || c == 26) expect_act(c + 2, 3'd2);
      drive((c >= 1 && c <= 29) ? 4'b0010 : 4'b0000, (c == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b1);
      tick();
    end
    end_scn("hold_right_missing");

    // Release right on the cycle-14 expiry: release wins, no request.
    base = cyc_cnt;
    for (int c = 0; c < 24; c++) begin
      if (c == 0 || c == 10) expect_act(c + 2, 3'd2);
      drive((c >= 1 && c <= 13) ? 4'b0010 : 4'b0000, (c == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b1);
      tick();
    end
    end_scn("release_on_expiry_missing");

    // Backpressure table, checked cycle by cycle.
    mon_en = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].dn, tbl[i].rdy, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), act_valid, tbl[i].exp_vld);
      chk($sformatf("vec%0d_code", i), act_code, tbl[i].exp_code);
      @(posedge clk);
      #1;
    end
    mon_en = 1'b1;

    // Left held, right pressed at 5: nothing while both held; left let go at 20 restarts right.
    base = cyc_cnt;
    for (int c = 0; c < 42; c++) begin
      logic [3:0] st;
      logic [3:0] dn;
      st = 4'b0000;
      dn = 4'b0000;
      if (c >= 1 && c <= 19) st[0] = 1'b1;
      if (c >= 6 && c <= 31) st[1] = 1'b1;
      if (c == 0) dn = 4'b0001;
      if (c == 5) dn = 4'b0010;
      if (c == 0) expect_act(2, 3'd1);
      if (c == 20 || c == 20 + DAS) expect_act(c + 2, 3'd2);
      drive(st, dn, 1'b1, 1'b1);
      tick();
    end
    end_scn("conflict_missing");

    // Soft drop every 3 cycles; enable low 7..12 kills the cycle-6 request and a rotate tap.
    base = cyc_cnt;
    for (int c = 0; c < 26; c++) begin
      logic [3:0] dn;
      dn = (c == 0) ? 4'b1000 : ((c == 9) ? 4'b0100 : 4'b0000);
      if (c == 0 || c == 3) expect_act(c + 2, 3'd4);
      drive((c >= 1 && c <= 20) ? 4'b1000 : 4'b0000, dn, 1'b1, !(c >= 7 && c <= 12));
      if (c == 8) begin
        @(negedge clk);
        chk("disabled_valid", act_valid, 0);
      end
      tick();
    end
    end_scn("soft_drop_missing");

    // Reset mid-repeat with an action stuck in the slot.
    base = cyc_cnt;
    for (int c = 0; c < 8; c++) begin
      drive((c >= 1) ? 4'b0010 : 4'b0000, (c == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b1);
      tick();
    end
    #2;
    chk("stuck_slot_valid", act_valid, 1);
    chk("stuck_slot_code", act_code, 2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", act_valid, 0);
    chk("async_reset_code", act_code, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    base = cyc_cnt;
    for (int c = 0; c < 26; c++) begin
      if (c == 20) expect_act(22, 3'd3);
      drive((c < 15) ? 4'b0010 : 4'b0000, (c == 20) ? 4'b0100 : 4'b0000, 1'b1, 1'b1);
      tick();
    end
    end_scn("post_reset_missing");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
